// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU operation sequencer: control-unit class
// selectors, funct7 groups, ALU/MDU operation codes and the FSM state type.
package alu_ctrl_pkg;

    // ALU_Op classes driven by the main control unit
    localparam logic [2:0] ALU_OP_R      = 3'b000;
    localparam logic [2:0] ALU_OP_I      = 3'b001;
    localparam logic [2:0] ALU_OP_LUI    = 3'b010;
    localparam logic [2:0] ALU_OP_BRANCH = 3'b011;
    localparam logic [2:0] ALU_OP_LDST   = 3'b100;
    localparam logic [2:0] ALU_OP_AUIPC  = 3'b101;
    localparam logic [2:0] ALU_OP_JAL    = 3'b110;

    // funct7 groups: base integer, alternate (SUB/SRA), M extension
    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    // Operation codes (5 bits is the minimum to carry the M-ext codes)
    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_XOR    = 5'd2;
    localparam logic [4:0] OP_OR     = 5'd3;
    localparam logic [4:0] OP_AND    = 5'd4;
    localparam logic [4:0] OP_SLL    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_SLT    = 5'd8;
    localparam logic [4:0] OP_SLTU   = 5'd9;
    localparam logic [4:0] OP_LUI    = 5'd10;
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_MULHU  = 5'd19;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_DIVU   = 5'd21;
    localparam logic [4:0] OP_REM    = 5'd22;
    localparam logic [4:0] OP_REMU   = 5'd23;

    // Sequencer states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } seq_state_e;

    // funct3 -> code for the base integer ops shared by R and I classes
    function automatic logic [4:0] base_code(input logic [2:0] funct3);
        logic [4:0] code;
        code = OP_ADD;
        case (funct3)
            3'd0:    code = OP_ADD;
            3'd1:    code = OP_SLL;
            3'd2:    code = OP_SLT;
            3'd3:    code = OP_SLTU;
            3'd4:    code = OP_XOR;
            3'd5:    code = OP_SRL;
            3'd6:    code = OP_OR;
            default: code = OP_AND;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational selector decode: {funct7, ALU_Op, funct3} -> operation code,
// multiply/divide class flags and an illegal flag. Illegal selectors map to ADD.
module alu_op_decode
    import alu_ctrl_pkg::*;
(
    input  logic [6:0] funct7_i,
    input  logic [2:0] ALU_Op_i,
    input  logic [2:0] funct3_i,
    output logic [4:0] code_o,
    output logic       is_mul_o,
    output logic       is_div_o,
    output logic       illegal_o
);

    // Decode the selector; any unmatched combination falls to illegal/ADD
    always_comb begin
        code_o    = OP_ADD;
        is_mul_o  = 1'b0;
        is_div_o  = 1'b0;
        illegal_o = 1'b0;
        case (ALU_Op_i)
            ALU_OP_R: begin
                case (funct7_i)
                    F7_BASE: code_o = base_code(funct3_i);
                    F7_ALT: begin
                        if (funct3_i == 3'd0)      code_o    = OP_SUB;
                        else if (funct3_i == 3'd5) code_o    = OP_SRA;
                        else                       illegal_o = 1'b1;
                    end
                    F7_MULDIV: begin
                        // MUL..MULHU occupy funct3 0-3, DIV..REMU occupy 4-7
                        code_o   = {2'b10, funct3_i};
                        is_mul_o = ~funct3_i[2];
                        is_div_o = funct3_i[2];
                    end
                    default: illegal_o = 1'b1;
                endcase
            end
            ALU_OP_I: begin
                // Only the shift immediates constrain funct7
                if (funct3_i == 3'd1) begin
                    if (funct7_i == F7_BASE) code_o    = OP_SLL;
                    else                     illegal_o = 1'b1;
                end else if (funct3_i == 3'd5) begin
                    if (funct7_i == F7_BASE)     code_o    = OP_SRL;
                    else if (funct7_i == F7_ALT) code_o    = OP_SRA;
                    else                         illegal_o = 1'b1;
                end else begin
                    code_o = base_code(funct3_i);
                end
            end
            ALU_OP_LUI:    code_o = OP_LUI;
            ALU_OP_BRANCH: code_o = OP_SUB;
            ALU_OP_LDST,
            ALU_OP_AUIPC,
            ALU_OP_JAL:    code_o = OP_ADD;
            default:       illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer. Registers the decoded operation code, issues base
// ops at one per cycle and holds multi-cycle M-ext ops with a busy counter.
// Handshake: an op is accepted when valid_i & ready_o at a rising edge;
// ready_o is high only in IDLE with kill_i low, and selector inputs are
// sampled only on accept. valid_o/illegal_o/mdu_start_o are one-cycle pulses.
module alu_op_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int OP_WIDTH   = 5,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic                kill_i,
    input  logic [6:0]          funct7_i,
    input  logic [2:0]          ALU_Op_i,
    input  logic [2:0]          funct3_i,
    output logic [OP_WIDTH-1:0] ALU_Operation_o,
    output logic                mdu_start_o,
    output logic                valid_o,
    output logic                illegal_o
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    seq_state_e           state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_load_d;
    logic [OP_WIDTH-1:0]  op_q;
    logic                 mdu_start_q;
    logic                 valid_q;
    logic                 illegal_q;

    logic [4:0]           dec_code;
    logic                 dec_is_mul;
    logic                 dec_is_div;
    logic                 dec_illegal;

    alu_op_decode u_decode (
        .funct7_i  (funct7_i),
        .ALU_Op_i  (ALU_Op_i),
        .funct3_i  (funct3_i),
        .code_o    (dec_code),
        .is_mul_o  (dec_is_mul),
        .is_div_o  (dec_is_div),
        .illegal_o (dec_illegal)
    );

    // Busy length for the op being offered: the count ends at 0 on the last busy cycle
    always_comb begin
        cnt_load_d = CNT_W'(MUL_CYCLES - 1);
        if (dec_is_div) cnt_load_d = CNT_W'(DIV_CYCLES - 1);
    end

    // Sequencer FSM, counter and registered outputs; reset beats kill beats accept
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            mdu_start_q <= 1'b0;
            valid_q     <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            mdu_start_q <= 1'b0;
            valid_q     <= 1'b0;
            illegal_q   <= 1'b0;
            if (kill_i) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        // ready_o is high here because kill_i is low
                        if (valid_i) begin
                            op_q <= OP_WIDTH'(dec_code);
                            if (dec_is_mul || dec_is_div) begin
                                mdu_start_q <= 1'b1;
                                cnt_q       <= cnt_load_d;
                                state_q     <= ST_BUSY;
                            end else begin
                                valid_q   <= 1'b1;
                                illegal_q <= dec_illegal;
                            end
                        end
                    end
                    ST_BUSY: begin
                        if (cnt_q == '0) begin
                            valid_q <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign ready_o         = (state_q == ST_IDLE) && !kill_i;
    assign ALU_Operation_o = op_q;
    assign mdu_start_o     = mdu_start_q;
    assign valid_o         = valid_q;
    assign illegal_o       = illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (default timing and a short
// MUL_CYCLES=1 / DIV_CYCLES=3 build) share one stimulus stream and are
// checked every cycle against a timeline reference model.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_i;
    logic       kill_i;
    logic [6:0] funct7_i;
    logic [2:0] alu_op_i;
    logic [2:0] funct3_i;

    logic [1:0]      rdy_w;
    logic [1:0]      start_w;
    logic [1:0]      vld_w;
    logic [1:0]      ill_w;
    logic [1:0][4:0] code_w;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // reference model: absolute cycle numbers of expected events per instance
    int mc[2] = '{4, 1};
    int dc[2] = '{32, 3};
    int busy_end[2];
    int valid_at[2];
    int illegal_at[2];
    int start_at[2];
    int exp_code[2];

    // clock / reset block
    always #5 clk = ~clk;

    alu_op_sequencer #(.OP_WIDTH(5), .MUL_CYCLES(4), .DIV_CYCLES(32)) dut0 (
        .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(rdy_w[0]),
        .kill_i(kill_i), .funct7_i(funct7_i), .ALU_Op_i(alu_op_i),
        .funct3_i(funct3_i), .ALU_Operation_o(code_w[0]),
        .mdu_start_o(start_w[0]), .valid_o(vld_w[0]), .illegal_o(ill_w[0])
    );

    alu_op_sequencer #(.OP_WIDTH(5), .MUL_CYCLES(1), .DIV_CYCLES(3)) dut1 (
        .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(rdy_w[1]),
        .kill_i(kill_i), .funct7_i(funct7_i), .ALU_Op_i(alu_op_i),
        .funct3_i(funct3_i), .ALU_Operation_o(code_w[1]),
        .mdu_start_o(start_w[1]), .valid_o(vld_w[1]), .illegal_o(ill_w[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // table-driven decode of the selector; kind 0 = single cycle, 1 = mul, 2 = div
    function automatic void ref_decode(input logic [6:0] f7, input logic [2:0] op,
                                       input logic [2:0] f3, output int code,
                                       output int kind, output bit ill);
        int base_tbl[8] = '{0, 5, 8, 9, 2, 6, 3, 4};
        code = 0;
        kind = 0;
        ill  = 1'b0;
        case (op)
            3'd0: begin
                if (f7 == 7'h00)      code = base_tbl[f3];
                else if (f7 == 7'h20) begin
                    if (f3 == 3'd0)      code = 1;
                    else if (f3 == 3'd5) code = 7;
                    else                 ill  = 1'b1;
                end else if (f7 == 7'h01) begin
                    code = 16 + int'(f3);
                    kind = (f3 < 3'd4) ? 1 : 2;
                end else ill = 1'b1;
            end
            3'd1: begin
                if (f3 == 3'd1)      begin if (f7 == 7'h00) code = 5; else ill = 1'b1; end
                else if (f3 == 3'd5) begin
                    if (f7 == 7'h00)      code = 6;
                    else if (f7 == 7'h20) code = 7;
                    else                  ill  = 1'b1;
                end else code = base_tbl[f3];
            end
            3'd2:    code = 10;
            3'd3:    code = 1;
            3'd7:    ill  = 1'b1;
            default: code = 0;
        endcase
        if (ill) begin
            code = 0;
            kind = 0;
        end
    endfunction

    function automatic void model_clear();
        for (int d = 0; d < 2; d++) begin
            busy_end[d]   = -1;
            valid_at[d]   = -1;
            illegal_at[d] = -1;
            start_at[d]   = -1;
            exp_code[d]   = 0;
        end
    endfunction

    // driver: entered #1 after a rising edge; checks this cycle's outputs,
    // applies inputs, advances the model across the next edge
    task automatic step(input logic rst, input logic v, input logic k,
                        input logic [6:0] f7, input logic [2:0] op, input logic [2:0] f3);
        int  code;
        int  kind;
        bit  ill;
        bit  busy;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("d%0d.valid", d),   32'(vld_w[d]),   32'(valid_at[d] == cyc));
            check_eq($sformatf("d%0d.illegal", d), 32'(ill_w[d]),   32'(illegal_at[d] == cyc));
            check_eq($sformatf("d%0d.start", d),   32'(start_w[d]), 32'(start_at[d] == cyc));
            check_eq($sformatf("d%0d.code", d),    32'(code_w[d]),  32'(exp_code[d]));
        end
        reset    = rst;
        valid_i  = v;
        kill_i   = k;
        funct7_i = f7;
        alu_op_i = op;
        funct3_i = f3;
        #1;
        ref_decode(f7, op, f3, code, kind, ill);
        for (int d = 0; d < 2; d++) begin
            busy = (cyc <= busy_end[d]);
            check_eq($sformatf("d%0d.ready", d), 32'(rdy_w[d]), 32'(!busy && !k));
            if (rst) begin
                busy_end[d]   = -1;
                valid_at[d]   = -1;
                illegal_at[d] = -1;
                start_at[d]   = -1;
                exp_code[d]   = 0;
            end else if (k) begin
                if (busy_end[d] > cyc)   busy_end[d]   = cyc;
                if (valid_at[d] > cyc)   valid_at[d]   = -1;
                if (illegal_at[d] > cyc) illegal_at[d] = -1;
            end else if (v && !busy) begin
                exp_code[d] = code;
                if (kind == 0) begin
                    valid_at[d] = cyc + 1;
                    if (ill) illegal_at[d] = cyc + 1;
                end else begin
                    start_at[d] = cyc + 1;
                    busy_end[d] = cyc + ((kind == 1) ? mc[d] : dc[d]);
                    valid_at[d] = busy_end[d] + 1;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 7'h00, 3'd0, 3'd0);
    endtask

    task automatic issue(input logic [6:0] f7, input logic [2:0] op, input logic [2:0] f3);
        step(1'b0, 1'b1, 1'b0, f7, op, f3);
    endtask

    task automatic kill_cycle();
        step(1'b0, 1'b0, 1'b1, 7'h00, 3'd0, 3'd0);
    endtask

    initial begin
        logic [6:0] f7;
        reset    = 1'b1;
        valid_i  = 1'b0;
        kill_i   = 1'b0;
        funct7_i = '0;
        alu_op_i = '0;
        funct3_i = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;

        // reset values, then R-type SUB and SRAI
        idle(1);
        issue(7'h20, 3'd0, 3'd0);
        issue(7'h20, 3'd1, 3'd5);
        idle(2);

        // back-to-back ADD, XOR, AND
        issue(7'h00, 3'd0, 3'd0);
        issue(7'h00, 3'd0, 3'd4);
        issue(7'h00, 3'd0, 3'd7);
        idle(2);

        // MUL, full duration on both builds
        issue(7'h01, 3'd0, 3'd0);
        idle(8);

        // DIVU killed at busy cycle 10
        issue(7'h01, 3'd0, 3'd5);
        idle(9);
        kill_cycle();
        idle(3);

        // DIVU killed in its last busy cycle (count at zero)
        issue(7'h01, 3'd0, 3'd5);
        idle(31);
        kill_cycle();
        idle(3);

        // MUL killed in its only busy cycle on the MUL_CYCLES=1 build
        issue(7'h01, 3'd0, 3'd1);
        kill_cycle();
        idle(6);

        // illegal class, then valid with kill while idle
        issue(7'h00, 3'd7, 3'd2);
        idle(1);
        step(1'b0, 1'b1, 1'b1, 7'h00, 3'd0, 3'd4);
        idle(2);

        // remaining fixed-code classes
        issue(7'h00, 3'd2, 3'd0);
        issue(7'h00, 3'd3, 3'd0);
        issue(7'h00, 3'd6, 3'd0);
        idle(1);

        // reset in the middle of a DIV
        issue(7'h01, 3'd0, 3'd4);
        idle(5);
        step(1'b1, 1'b1, 1'b0, 7'h00, 3'd0, 3'd0);
        step(1'b1, 1'b0, 1'b0, 7'h00, 3'd0, 3'd0);
        idle(3);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 3))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                2:       f7 = 7'h01;
                default: f7 = 7'($urandom_range(0, 127));
            endcase
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < 60),
                 ($urandom_range(0, 99) < 3),
                 f7, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end
        idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
